// File: rtl/demux_1to3_reg.sv
// One-to-three registered demultiplexer with a one-entry buffer per output channel
// and a saturating counter for illegal-select accepts.
module demux_1to3_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic             err,
  output logic [7:0]       err_count
);

  typedef enum logic {StEmpty, StFull} ch_state_e;

  ch_state_e        r_state [3];
  ch_state_e        w_state_next [3];
  logic [WIDTH-1:0] r_data [3];
  logic             r_err;
  logic [7:0]       r_err_count;

  logic             w_illegal;
  logic             w_accept;
  logic [2:0]       w_acc_ch;
  logic [2:0]       w_deliver;
  logic [2:0]       w_full;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_full[i] = (r_state[i] == StFull);
    end
  end

  assign w_illegal = (in_sel == 2'b11);

  // Illegal selects are always accepted so they can be discarded and counted.
  always_comb begin
    in_ready = 1'b1;
    unique case (in_sel)
      2'b00:   in_ready = ~w_full[0] | out_ready[0];
      2'b01:   in_ready = ~w_full[1] | out_ready[1];
      2'b10:   in_ready = ~w_full[2] | out_ready[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_acc_ch[i]  = w_accept & ~w_illegal & (in_sel == 2'(i));
      w_deliver[i] = w_full[i] & out_ready[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_state_next[i] = r_state[i];
      unique case (r_state[i])
        StEmpty: begin
          if (w_acc_ch[i]) w_state_next[i] = StFull;
        end
        StFull: begin
          // A deliver coinciding with an accept refills the slot without a bubble.
          if (!w_acc_ch[i] && w_deliver[i]) w_state_next[i] = StEmpty;
        end
        default: w_state_next[i] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= StEmpty;
        r_data[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_state[i] <= w_state_next[i];
        if (w_acc_ch[i]) r_data[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_err <= w_accept & w_illegal;
      if (w_accept && w_illegal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign out1      = r_data[0];
  assign out2      = r_data[1];
  assign out3      = r_data[2];
  assign out_valid = w_full;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_demux_1to3_reg.sv
// Randomized and directed bench for demux_1to3_reg against a per-channel slot model.
module tb_demux_1to3_reg;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic             err;
  logic [7:0]       err_count;

  demux_1to3_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a slot per channel plus the error bookkeeping.
  bit         m_full [3];
  int         m_data [3];
  bit         m_err;
  int         m_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic bit m_ready(input int sel, input logic [2:0] rdy);
    if (sel == 3) return 1'b1;
    return !m_full[sel] || rdy[sel];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_full[c] = 1'b0;
      m_data[c] = 0;
    end
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), {29'd0, m_full[2], m_full[1], m_full[0]});
    chk({tag, ".out1"}, 32'(out1), m_data[0]);
    chk({tag, ".out2"}, 32'(out2), m_data[1]);
    chk({tag, ".out3"}, 32'(out3), m_data[2]);
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".err_count"}, 32'(err_count), m_cnt);
  endtask

  // One cycle: drive, check in_ready, clock, update model, check outputs.
  task automatic step(input bit v, input int sel, input int data, input logic [2:0] rdy,
                      input string tag);
    bit acc;
    @(negedge clk);
    in_valid  = v;
    in_sel    = 2'(sel);
    in_data   = WIDTH'(data);
    out_ready = rdy;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready(sel, rdy)));
    acc = v && m_ready(sel, rdy);
    @(posedge clk);
    m_err = 1'b0;
    for (int c = 0; c < 3; c++) if (m_full[c] && rdy[c]) m_full[c] = 1'b0;
    if (acc) begin
      if (sel == 3) begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_full[sel] = 1'b1;
        m_data[sel] = data & 'hFF;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sel    = 2'b01;
    in_data   = 8'h77;
    out_ready = 3'b111;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    in_ready_chk : chk({tag, ".in_ready_rst"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = '0;
    out_ready = 3'b000;
    model_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single accept, then backpressure on a full channel.
    step(1, 1, 'hA5, 3'b000, "acc_a5");
    chk("a5_direct", 32'(out2), 32'hA5);
    step(1, 1, 'h5A, 3'b000, "blocked");
    chk("a5_held", 32'(out2), 32'hA5);

    // Simultaneous deliver and replace.
    do_reset("r1");
    step(1, 1, 'h3C, 3'b000, "fill_3c");
    step(1, 1, 'hC3, 3'b010, "replace");
    chk("c3_direct", 32'(out2), 32'hC3);

    // Fill all three, drain all at once.
    do_reset("r2");
    step(1, 0, 'h11, 3'b000, "fill1");
    step(1, 1, 'h22, 3'b000, "fill2");
    step(1, 2, 'h33, 3'b000, "fill3");
    chk("all_full", 32'(out_valid), 32'h7);
    step(0, 0, 0, 3'b111, "drain");
    chk("drained", 32'(out_valid), 32'h0);
    chk("retain3", 32'(out3), 32'h33);

    // Illegal selects: error pulse train and count.
    do_reset("r3");
    step(1, 0, 'h44, 3'b000, "pre_ill");
    for (int i = 0; i < 3; i++) step(1, 3, 'hEE, 3'b000, "illegal");
    step(0, 3, 'hEE, 3'b000, "ill_tail");
    chk("cnt3", 32'(err_count), 32'd3);

    // Idle cycles with a tempting select must change nothing.
    for (int i = 0; i < 5; i++) step(0, 2, 'hFF, 3'b000, "idle");

    // Reset while out_valid = 101.
    do_reset("r4");
    step(1, 0, 'h12, 3'b000, "v101a");
    step(1, 2, 'h34, 3'b000, "v101b");
    chk("v101", 32'(out_valid), 32'h5);
    do_reset("r5");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 255),
           3'($urandom), "rand");
    end

    // Saturation of the error counter.
    do_reset("r6");
    for (int i = 0; i < 260; i++) step(1, 3, $urandom_range(0, 255), 3'($urandom), "sat");
    chk("sat255", 32'(err_count), 32'd255);
    chk("sat_err", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
